boot_sequencer: RTL and testbench
=================================

// Module: boot_sequencer
// PURPOSE
//  Sequences processor start-up once the board power rail is up.
//  - Debounces is_powered_on (the boot-control output).
//  - Copies COPY_LEN words from the boot ROM into main RAM.
//  - Then releases CPU reset.
//  Sits between boot control, boot ROM, RAM write port and the CPU core reset input.
// PARAMETERS
//  AW            8    ROM/RAM word address width
//  DW            8    data word width
//  COPY_LEN      16   words copied, ROM[0..COPY_LEN-1] -> RAM[0..COPY_LEN-1]; legal range 1..2**AW
//  STABLE_CYCLES 8    consecutive powered cycles required before the copy starts; >=1
//  ACK_TIMEOUT   15   max cycles ram_we may wait for ram_ack before FAULT; >=1
// PORTS
//  clk           in   1   system clock, all logic on the rising edge
//  reset_n       in   1   synchronous, active-low reset
//  is_powered_on in   1   power-good from boot control, treated as synchronous
//  rom_addr      out  AW  boot ROM read address, registered
//  rom_data      in   DW  boot ROM data, valid 1 cycle after rom_addr is presented
//  ram_we        out  1   RAM write request, held until ram_ack
//  ram_addr      out  AW  RAM write address, registered
//  ram_wdata     out  DW  RAM write data, registered
//  ram_ack       in   1   RAM write accepted this cycle
//  cpu_reset_n   out  1   active-low CPU reset, high only in RUN
//  boot_done     out  1   copy complete, CPU running
//  boot_error    out  1   RAM ack timeout, sticky
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge), applied mid-operation too:
//    - state=OFF, idx=0, counters=0.
//    - rom_addr=0, ram_addr=0, ram_wdata=0.
//    - ram_we=0, cpu_reset_n=0, boot_done=0, boot_error=0.
//  - FSM, all outputs registered:
//    - OFF: wait for is_powered_on=1, then go to STAB with cnt=0.
//    - STAB: cnt++ each cycle. At cnt==STABLE_CYCLES-1, go to RD with idx=0.
//    - RD: rom_addr<=idx, then go to LAT.
//    - LAT: ram_wdata<=rom_data, ram_addr<=idx, ram_we<=1, tmo=0, then go to WR.
//    - WR: ram_we held, addr/data held stable.
//      - ram_ack=1: ram_we<=0.
//        - idx==COPY_LEN-1: go to RUN.
//        - otherwise: idx++ and go to RD.
//      - no ack: tmo++. At tmo==ACK_TIMEOUT-1, go to FAULT.
//    - RUN: cpu_reset_n=1, boot_done=1, until power loss.
//    - FAULT: ram_we=0, boot_error=1, cpu_reset_n=0. Left only via reset or power loss.
//  - Brown-out: is_powered_on=0 in any state other than OFF.
//    - Next state is OFF and every output takes its reset value, including boot_error.
//    - This wins over a simultaneous ram_ack; that word is not counted.
//  - ram_ack outside WR is ignored.
//  - Latency, ack in the same cycle as the request:
//    - is_powered_on rises at edge k; boot_done=1 from edge k+1+STABLE_CYCLES+3*COPY_LEN.
//    - Each extra ack-wait cycle adds 1.
//  - Width rules:
//    - idx is AW+1 bits, so COPY_LEN=2**AW has no wrap-around.
//    - rom_addr and ram_addr carry idx[AW-1:0].
//    - cnt is $clog2(STABLE_CYCLES+1) bits; tmo is $clog2(ACK_TIMEOUT+1) bits.
// STRUCTURE
//  - Shared package boot_seq_pkg holds:
//    - state encoding localparams: OFF, STAB, RD, LAT, WR, RUN, FAULT (3 bits);
//    - default STABLE_CYCLES and ACK_TIMEOUT.
//  - One sub-module, boot_delay_counter (clear, enable, terminal-count compare, parameterised
//    width), instantiated twice: the stabilisation counter and the ack timeout.
// TESTING
//  - Reset/idle: reset_n=0 for 2 cycles, power=0 -> all outputs 0 and rom_addr=0 for 20 cycles.
//  - Nominal, COPY_LEN=4, STABLE_CYCLES=8, ROM={11,22,33,44}, ack in the same cycle:
//    - RAM receives writes addr0..3 = 11,22,33,44 in order;
//    - boot_done and cpu_reset_n rise exactly 21 cycles after power rises.
//  - Back-pressure: ack delayed 3 cycles on word 2 ->
//    - ram_we, ram_addr=2 and ram_wdata=33 stable throughout the wait;
//    - boot_done is 3 cycles late.
//  - Timeout, ACK_TIMEOUT=15, ack never returned on word 1 ->
//    - FAULT 15 cycles after ram_we rises;
//    - boot_error=1, ram_we=0, cpu_reset_n=0.
//  - Brown-out:
//    - power=0 in STAB at cnt=5 -> OFF; power=1 again -> full 8-cycle wait restarts.
//    - power=0 in RUN -> cpu_reset_n=0 and boot_done=0 next edge.
//  - Power loss on the same edge as ram_ack for word 3 ->
//    - OFF, ram_we=0;
//    - re-boot rewrites from addr 0.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// -----------------------------------------------------------------------------
// boot_seq_pkg
// Shared definitions for the boot sequencer: the 3-bit state encoding and the
// default stabilisation / RAM-acknowledge timing values.
// -----------------------------------------------------------------------------
package boot_seq_pkg;

    // State encoding values
    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_STAB  = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_LAT   = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    typedef enum logic [2:0] {
        ST_OFF   = S_OFF,
        ST_STAB  = S_STAB,
        ST_RD    = S_RD,
        ST_LAT   = S_LAT,
        ST_WR    = S_WR,
        ST_RUN   = S_RUN,
        ST_FAULT = S_FAULT
    } boot_state_e;

    // Default timing values
    localparam int unsigned DEF_STABLE_CYCLES = 32'd8;
    localparam int unsigned DEF_ACK_TIMEOUT   = 32'd15;

    // True for the only state in which the CPU is allowed out of reset
    function automatic logic state_is_run(input boot_state_e s);
        return (s == ST_RUN);
    endfunction

endpackage

// File: rtl/boot_delay_counter.sv
// -----------------------------------------------------------------------------
// boot_delay_counter
// Small up-counter with synchronous clear and enable, flagging when the count
// equals a fixed terminal value. The count saturates at the terminal value so
// it can never wrap while the owner is still looking at it.
// Ports:
//   clk          in  1  system clock (rising edge)
//   reset_n      in  1  synchronous active-low reset
//   clear        in  1  force count to zero on the next edge (beats enable)
//   enable       in  1  advance the count by one on the next edge
//   at_terminal  out 1  count currently equals TERMINAL
// -----------------------------------------------------------------------------
module boot_delay_counter #(
    parameter int unsigned WIDTH    = 32'd4,
    parameter int unsigned TERMINAL = 32'd7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic at_terminal
);

    localparam logic [WIDTH-1:0] TERM_W = WIDTH'(TERMINAL);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_terminal = (count_q == TERM_W);

    // Next-count selection: clear first, then saturating increment
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {WIDTH{1'b0}};
        end else if (enable && !at_terminal) begin
            count_d = count_q + ONE_W;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// -----------------------------------------------------------------------------
// boot_sequencer
// Brings the processor up once the power rail is good: waits for
// STABLE_CYCLES consecutive powered cycles, copies COPY_LEN words from the
// boot ROM into RAM (one RAM write in flight at a time, with an ack timeout),
// then releases the CPU reset. Losing power anywhere returns everything to
// the reset state, including a latched boot error.
// Ports:
//   clk            in  1   system clock (rising edge)
//   reset_n        in  1   synchronous active-low reset
//   is_powered_on  in  1   power-good from boot control (synchronous)
//   rom_addr       out AW  boot ROM read address (registered)
//   rom_data       in  DW  ROM data for the address presented last cycle
//   ram_we         out 1   RAM write request, held until ram_ack
//   ram_addr       out AW  RAM write address (registered)
//   ram_wdata      out DW  RAM write data (registered)
//   ram_ack        in  1   RAM accepted the write this cycle
//   cpu_reset_n    out 1   active-low CPU reset, high only while running
//   boot_done      out 1   copy finished and CPU running
//   boot_error     out 1   RAM ack timed out (held until reset/power loss)
// -----------------------------------------------------------------------------
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int unsigned AW            = 32'd8,
    parameter int unsigned DW            = 32'd8,
    parameter int unsigned COPY_LEN      = 32'd16,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          is_powered_on,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic          ram_ack,
    output logic          cpu_reset_n,
    output logic          boot_done,
    output logic          boot_error
);

    // idx is one bit wider than an address so COPY_LEN == 2**AW terminates
    localparam int unsigned IW = AW + 32'd1;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 32'd1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 32'd1);
    localparam logic [IW-1:0] LAST_IDX = IW'(COPY_LEN - 32'd1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    boot_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic          ram_we_q, ram_we_d;
    logic          cpu_reset_n_q, cpu_reset_n_d;
    logic          boot_done_q, boot_done_d;
    logic          boot_error_q, boot_error_d;

    logic          stab_done_s;
    logic          tmo_done_s;
    logic          stab_clear_s;
    logic          stab_en_s;
    logic          tmo_clear_s;
    logic          tmo_en_s;

    // The stabilisation count only runs in STAB and restarts from zero on
    // every entry; the ack timeout only runs while a write waits unacked.
    assign stab_clear_s = (state_q != ST_STAB);
    assign stab_en_s    = (state_q == ST_STAB);
    assign tmo_clear_s  = (state_q != ST_WR);
    assign tmo_en_s     = (state_q == ST_WR) && !ram_ack;

    boot_delay_counter #(
        .WIDTH    (CW),
        .TERMINAL (STABLE_CYCLES - 32'd1)
    ) u_stab_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (stab_clear_s),
        .enable      (stab_en_s),
        .at_terminal (stab_done_s)
    );

    boot_delay_counter #(
        .WIDTH    (TW),
        .TERMINAL (ACK_TIMEOUT - 32'd1)
    ) u_tmo_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (tmo_clear_s),
        .enable      (tmo_en_s),
        .at_terminal (tmo_done_s)
    );

    // Next-state and next-output logic; power loss overrides everything
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = ram_we_q;

        if (!is_powered_on) begin
            // Brown-out: back to the reset picture, even over a pending ack
            state_d     = ST_OFF;
            idx_d       = {IW{1'b0}};
            rom_addr_d  = {AW{1'b0}};
            ram_addr_d  = {AW{1'b0}};
            ram_wdata_d = {DW{1'b0}};
            ram_we_d    = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_STAB;
                    idx_d   = {IW{1'b0}};
                end
                ST_STAB: begin
                    if (stab_done_s) begin
                        state_d = ST_RD;
                        idx_d   = {IW{1'b0}};
                    end else begin
                        state_d = ST_STAB;
                    end
                end
                ST_RD: begin
                    rom_addr_d = idx_q[AW-1:0];
                    state_d    = ST_LAT;
                end
                ST_LAT: begin
                    ram_wdata_d = rom_data;
                    ram_addr_d  = idx_q[AW-1:0];
                    ram_we_d    = 1'b1;
                    state_d     = ST_WR;
                end
                ST_WR: begin
                    if (ram_ack) begin
                        ram_we_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = ST_RD;
                        end
                    end else if (tmo_done_s) begin
                        ram_we_d = 1'b0;
                        state_d  = ST_FAULT;
                    end else begin
                        state_d = ST_WR;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_FAULT: begin
                    ram_we_d = 1'b0;
                    state_d  = ST_FAULT;
                end
                default: begin
                    state_d  = ST_OFF;
                    ram_we_d = 1'b0;
                end
            endcase
        end

        // Status outputs follow the state being entered so they are registered
        cpu_reset_n_d = state_is_run(state_d);
        boot_done_d   = state_is_run(state_d);
        boot_error_d  = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_OFF;
            idx_q         <= {IW{1'b0}};
            rom_addr_q    <= {AW{1'b0}};
            ram_addr_q    <= {AW{1'b0}};
            ram_wdata_q   <= {DW{1'b0}};
            ram_we_q      <= 1'b0;
            cpu_reset_n_q <= 1'b0;
            boot_done_q   <= 1'b0;
            boot_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rom_addr_q    <= rom_addr_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_we_q      <= ram_we_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            boot_done_q   <= boot_done_d;
            boot_error_q  <= boot_error_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_we      = ram_we_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign boot_done   = boot_done_q;
    assign boot_error  = boot_error_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_boot_sequencer
// Directed bench for boot_sequencer (COPY_LEN=4, STABLE_CYCLES=8,
// ACK_TIMEOUT=15). A timing model of the boot flow predicts every output each
// cycle; directed scenarios add hand-computed latency and data expectations.
// -----------------------------------------------------------------------------
module tb_boot_sequencer;

    localparam int S = 8;
    localparam int T = 15;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       is_powered_on;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_ack;
    logic       cpu_reset_n;
    logic       boot_done;
    logic       boot_error;

    logic [7:0] rom [0:255];
    logic       resp_ack = 1'b0;
    logic       ack_force = 1'b0;
    int         ack_delay [0:3];
    int         wcnt = 0;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    int we_cyc [0:3];
    int we_bad;

    logic [7:0] wlog_a [0:63];
    logic [7:0] wlog_d [0:63];
    int         wlog_n = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    assign ram_ack  = resp_ack | ack_force;

    boot_sequencer #(
        .AW(8), .DW(8), .COPY_LEN(L), .STABLE_CYCLES(S), .ACK_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset_n(reset_n), .is_powered_on(is_powered_on),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_ack(ram_ack), .cpu_reset_n(cpu_reset_n),
        .boot_done(boot_done), .boot_error(boot_error)
    );

    // ---------------- timing model ----------------
    // Tracks how far the boot has got: powered edges spent settling, which
    // word is being copied and how many edges that word has consumed.
    logic       m_active = 1'b0, m_copy = 1'b0, m_done = 1'b0, m_err = 1'b0;
    int         m_t = 0, m_word = 0, m_e = 0;
    logic [7:0] x_rom = 8'd0, x_raddr = 8'd0, x_wdata = 8'd0;
    logic       x_we = 1'b0;

    always @(posedge clk) begin
        if (!reset_n || !is_powered_on) begin
            m_active <= 1'b0; m_copy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_t <= 0; m_word <= 0; m_e <= 0;
            x_rom <= 8'd0; x_raddr <= 8'd0; x_wdata <= 8'd0; x_we <= 1'b0;
        end else if (!m_active) begin
            m_active <= 1'b1;
            m_t      <= 0;
        end else if (m_done || m_err) begin
            m_t <= m_t;
        end else if (!m_copy) begin
            m_t <= m_t + 1;
            if (m_t + 1 == S) begin
                m_copy <= 1'b1; m_word <= 0; m_e <= 0;
            end
        end else if (m_e == 0) begin
            x_rom <= 8'(m_word);
            m_e   <= 1;
        end else if (m_e == 1) begin
            x_wdata <= rom[m_word];
            x_raddr <= 8'(m_word);
            x_we    <= 1'b1;
            m_e     <= 2;
        end else if (ram_ack) begin
            x_we <= 1'b0;
            if (m_word == L - 1) begin
                m_copy <= 1'b0; m_done <= 1'b1;
            end else begin
                m_word <= m_word + 1; m_e <= 0;
            end
        end else if (m_e - 2 == T - 1) begin
            x_we <= 1'b0; m_copy <= 1'b0; m_err <= 1'b1;
        end else begin
            m_e <= m_e + 1;
        end
    end

    // Log of RAM writes the sequencer actually got accepted
    always @(posedge clk) begin
        if (reset_n && is_powered_on && ram_we === 1'b1 && ram_ack === 1'b1) begin
            wlog_a[wlog_n % 64] <= ram_addr;
            wlog_d[wlog_n % 64] <= ram_wdata;
            wlog_n <= wlog_n + 1;
        end
    end

    // Per-cycle comparison of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_cmp++;
                if ({rom_addr, ram_addr, ram_wdata, ram_we, cpu_reset_n, boot_done, boot_error} !==
                    {x_rom, x_raddr, x_wdata, x_we, m_done, m_done, m_err}) begin
                    n_err++;
                    $display("FAIL cycle_model t=%0t act rom=%h ra=%h wd=%h we=%b crn=%b done=%b err=%b req rom=%h ra=%h wd=%h we=%b crn=%b done=%b err=%b",
                             $time, rom_addr, ram_addr, ram_wdata, ram_we, cpu_reset_n, boot_done, boot_error,
                             x_rom, x_raddr, x_wdata, x_we, m_done, m_done, m_err);
                end
            end
        end
    end

    // RAM ack responder: acks each word after ack_delay[word] waiting cycles
    initial begin
        forever begin
            @(negedge clk);
            if (ram_we !== 1'b1) begin
                resp_ack = 1'b0;
                wcnt     = 0;
            end else if (wcnt >= ack_delay[ram_addr[1:0]]) begin
                resp_ack = 1'b1;
            end else begin
                resp_ack = 1'b0;
                wcnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d req=%0d", name, act, exp);
        end
    endtask

    // Raise power at this negedge and count cycles until done or error
    task automatic boot_until(input int force_n, output int lat);
        int n;
        lat = -1;
        n   = 0;
        for (int i = 0; i < 4; i++) we_cyc[i] = 0;
        we_bad = 0;
        is_powered_on = 1'b1;
        if (force_n > 0) ack_force = 1'b1;
        while (lat < 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (n == force_n) ack_force = 1'b0;
            if (ram_we === 1'b1) begin
                we_cyc[ram_addr[1:0]]++;
                if (ram_wdata !== rom[ram_addr]) we_bad++;
            end
            if (boot_done === 1'b1 || boot_error === 1'b1) lat = n;
        end
    endtask

    task automatic power_off(input int cycles);
        is_powered_on = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int lat;
        int base;
        int idle_or;
        int n;
        int exp_d [0:3];
        exp_d = '{11, 22, 33, 44};

        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'hA5;
        rom[0] = 8'd11; rom[1] = 8'd22; rom[2] = 8'd33; rom[3] = 8'd44;
        for (int i = 0; i < 4; i++) ack_delay[i] = 0;

        // Reset and idle with power low
        reset_n = 1'b0;
        is_powered_on = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        idle_or = 0;
        repeat (20) begin
            @(negedge clk);
            idle_or = idle_or | int'({rom_addr, ram_addr, ram_wdata, ram_we, cpu_reset_n, boot_done, boot_error});
        end
        check("idle_outputs_zero", idle_or, 0);

        // Nominal boot; stray acks during settling/RD must be ignored
        base = wlog_n;
        boot_until(10, lat);
        check("nominal_latency", lat, 21);
        check("nominal_cpu_reset_n", int'(cpu_reset_n), 1);
        check("nominal_write_count", wlog_n - base, 4);
        for (int i = 0; i < 4; i++) begin
            check("nominal_addr", int'(wlog_a[(base + i) % 64]), i);
            check("nominal_data", int'(wlog_d[(base + i) % 64]), exp_d[i]);
        end

        // Power loss while running
        is_powered_on = 1'b0;
        @(negedge clk);
        check("run_brownout_done", int'(boot_done), 0);
        check("run_brownout_cpu_rst", int'(cpu_reset_n), 0);
        power_off(3);

        // Back-pressure: word 2 acked after three extra cycles
        ack_delay[2] = 3;
        boot_until(0, lat);
        check("bp_latency", lat, 24);
        check("bp_word2_cycles", we_cyc[2], 4);
        check("bp_data_stable", we_bad, 0);
        ack_delay[2] = 0;
        power_off(3);

        // Timeout: word 1 never acked
        ack_delay[1] = 1000;
        boot_until(0, lat);
        check("tmo_latency", lat, 29);
        check("tmo_we_cycles", we_cyc[1], 15);
        check("tmo_boot_error", int'(boot_error), 1);
        check("tmo_ram_we", int'(ram_we), 0);
        check("tmo_cpu_reset_n", int'(cpu_reset_n), 0);
        repeat (5) @(negedge clk);
        check("tmo_error_sticky", int'(boot_error), 1);
        is_powered_on = 1'b0;
        @(negedge clk);
        check("tmo_error_cleared_by_brownout", int'(boot_error), 0);
        ack_delay[1] = 0;
        power_off(3);

        // Brown-out during settling at cnt=5, then a full restart
        is_powered_on = 1'b1;
        repeat (6) @(negedge clk);
        is_powered_on = 1'b0;
        @(negedge clk);
        boot_until(0, lat);
        check("stab_restart_latency", lat, 21);

        // Reset while running, then boot again with power held high
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_done", int'(boot_done), 0);
        check("midreset_cpu_rst", int'(cpu_reset_n), 0);
        reset_n = 1'b1;
        boot_until(0, lat);
        check("midreset_reboot_latency", lat, 21);
        power_off(3);

        // Power lost on the same edge as the ack of word 3
        base = wlog_n;
        is_powered_on = 1'b1;
        n = 0;
        while (!(ram_we === 1'b1 && ram_addr == 8'd3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w3_reached", int'(n < 100), 1);
        is_powered_on = 1'b0;
        @(negedge clk);
        check("w3_loss_ram_we", int'(ram_we), 0);
        check("w3_loss_done", int'(boot_done), 0);
        check("w3_loss_write_count", wlog_n - base, 3);
        repeat (2) @(negedge clk);
        base = wlog_n;
        boot_until(0, lat);
        check("w3_reboot_latency", lat, 21);
        check("w3_reboot_write_count", wlog_n - base, 4);
        for (int i = 0; i < 4; i++) begin
            check("w3_reboot_addr", int'(wlog_a[(base + i) % 64]), i);
        end
        power_off(3);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
